uart_rx_oversampled: RTL and testbench

//  Parametrised UART receiver: synchronises async rx line, detects start bit by

---
 rtl/uart_rx_oversampled.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// uart_rx_oversampled : oversampling UART receiver with a one-word output buffer
// Revision 1.0
// ============================================================================
module uart_rx_oversampled #(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE      = 16,
  parameter int CLKS_PER_SAMPLE = 27,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  input  logic                 clear_overrun,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 tick;
  logic                 last_sample;

  always_comb begin
    sync_d      = {sync_q[0], rx};
    rx_s        = sync_q[1];
    tick        = (tick_cnt_q == CNT_W'(CLKS_PER_SAMPLE - 1));
    tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);
    last_sample = (sc_q == SC_W'(OVERSAMPLE - 1));

    state_d    = state_q;
    sc_d       = sc_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    commit_d   = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            sc_d    = '0;
          end
        end
        // The detecting tick is tick 0, so the check lands mid start bit.
        START: begin
          if (sc_q == SC_W'(OVERSAMPLE / 2 - 1)) begin
            sc_d       = '0;
            bit_cnt_d  = '0;
            ferr_acc_d = 1'b0;
            perr_acc_d = 1'b0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        DATA: begin
          if (last_sample) begin
            sc_d      = '0;
            shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        PARITY: begin
          if (last_sample) begin
            sc_d       = '0;
            perr_acc_d = ((^shreg_q) ^ rx_s) != 1'(PARITY_ODD);
            state_d    = STOP;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        STOP: begin
          if (last_sample) begin
            sc_d = '0;
            if (!rx_s) ferr_acc_d = 1'b1;
            if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
              commit_d = 1'b1;
              state_d  = rx_s ? IDLE : BREAK;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = ovr_q;
    // A commit into a full, unacknowledged buffer drops the new word.
    if (commit_q && (!valid_q || data_ready)) begin
      data_d  = shreg_q;
      fe_d    = ferr_acc_q;
      pe_d    = perr_acc_q;
      valid_d = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (commit_q && valid_q && !data_ready) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      sc_q       <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      sc_q       <= sc_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = fe_q;
  assign parity_error  = pe_q;
  assign overrun       = ovr_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_oversampled : scoreboard bench for 8N1 and 8E1 receiver instances
// Revision 1.0
// ============================================================================
module tb_uart_rx_oversampled;

  localparam int BIT = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, rx, rx_p, data_ready, clear_overrun;
  logic [7:0] dout, dout_p;
  logic       dv, fe, pe, ovr, busy;
  logic       dv_p, fe_p, pe_p, ovr_p, busy_p;

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(16), .CLKS_PER_SAMPLE(4),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx), .data_out(dout),
    .data_valid(dv), .data_ready(data_ready), .framing_error(fe),
    .parity_error(pe), .overrun(ovr), .clear_overrun(clear_overrun), .busy(busy)
  );

  uart_rx_oversampled #(
    .DATA_BITS(8), .OVERSAMPLE(16), .CLKS_PER_SAMPLE(4),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_p (
    .clock(clock), .reset_n(reset_n), .rx(rx_p), .data_out(dout_p),
    .data_valid(dv_p), .data_ready(1'b1), .framing_error(fe_p),
    .parity_error(pe_p), .overrun(ovr_p), .clear_overrun(1'b0), .busy(busy_p)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_p[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon_a
    exp_t e;
    if (reset_n && dv && data_ready) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected word on 8N1: got 0x%0h, expected none", dout);
      end else begin
        e = q_a.pop_front();
        check("8N1 data_out", 32'(dout), 32'(e.d));
        check("8N1 framing_error", 32'(fe), 32'(e.fe));
        check("8N1 parity_error", 32'(pe), 32'(e.pe));
      end
    end
  end

  always @(negedge clock) begin : mon_p
    exp_t e;
    if (reset_n && dv_p) begin
      if (q_p.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected word on 8E1: got 0x%0h, expected none", dout_p);
      end else begin
        e = q_p.pop_front();
        check("8E1 data_out", 32'(dout_p), 32'(e.d));
        check("8E1 framing_error", 32'(fe_p), 32'(e.fe));
        check("8E1 parity_error", 32'(pe_p), 32'(e.pe));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hold(input bit sel, input logic v, input int n);
    if (sel) rx_p = v;
    else     rx   = v;
    wait_clk(n);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit par,
                      input logic pbit, input logic stopv, input int gap);
    hold(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(sel, d[i], BIT);
    if (par) hold(sel, pbit, BIT);
    hold(sel, stopv, BIT);
    if (gap > 0) hold(sel, 1'b1, gap);
  endtask

  initial begin
    bit saw_busy;
    reset_n       = 1'b0;
    rx            = 1'b1;
    rx_p          = 1'b1;
    data_ready    = 1'b1;
    clear_overrun = 1'b0;
    wait_clk(3);
    check("reset data_out", 32'(dout), 32'h0);
    check("reset data_valid", 32'(dv), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset overrun", 32'(ovr), 32'h0);
    check("reset flags", 32'({fe, pe}), 32'h0);
    check("reset 8E1 valid/busy", 32'({dv_p, busy_p}), 32'h0);
    reset_n = 1'b1;
    wait_clk(10);

    q_a.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send(0, 8'hA5, 0, 1'b0, 1'b1, 2 * BIT);
    check("8N1 valid is a single-cycle pulse", 32'(dv), 32'h0);

    // Short low pulse: start bit rejected at its centre check.
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_clk(1);
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    wait_clk(40);
    check("glitch raised busy", 32'(saw_busy), 32'h1);
    check("glitch busy back to 0", 32'(busy), 32'h0);
    wait_clk(BIT);

    q_a.push_back('{d: 8'h3C, fe: 1'b1, pe: 1'b0});
    send(0, 8'h3C, 0, 1'b0, 1'b0, 0);
    hold(0, 1'b0, 200);
    check("break keeps busy", 32'(busy), 32'h1);
    hold(0, 1'b1, 3 * BIT);
    check("break exits to idle", 32'(busy), 32'h0);

    q_p.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
    send(1, 8'h07, 1, 1'b0, 1'b1, 2 * BIT);
    q_p.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    send(1, 8'h07, 1, 1'b1, 1'b1, 2 * BIT);

    data_ready = 1'b0;
    q_a.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send(0, 8'h11, 0, 1'b0, 1'b1, BIT);
    send(0, 8'h22, 0, 1'b0, 1'b1, BIT);
    check("overrun buffer keeps first word", 32'(dout), 32'h11);
    check("overrun buffer still valid", 32'(dv), 32'h1);
    check("overrun set on drop", 32'(ovr), 32'h1);
    data_ready = 1'b1;
    wait_clk(1);
    data_ready = 1'b0;
    check("valid cleared after handshake", 32'(dv), 32'h0);
    check("overrun sticky after handshake", 32'(ovr), 32'h1);
    clear_overrun = 1'b1;
    wait_clk(1);
    clear_overrun = 1'b0;
    check("overrun cleared", 32'(ovr), 32'h0);
    data_ready = 1'b1;
    wait_clk(BIT);

    // Abort a 0xFF frame partway through its data bits.
    hold(0, 1'b0, BIT);
    hold(0, 1'b1, 3 * BIT);
    check("busy mid-frame", 32'(busy), 32'h1);
    reset_n = 1'b0;
    rx      = 1'b1;
    #1;
    check("async reset data_out", 32'(dout), 32'h0);
    check("async reset busy", 32'(busy), 32'h0);
    check("async reset valid/flags/overrun", 32'({dv, fe, pe, ovr}), 32'h0);
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(10);
    q_a.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
    send(0, 8'h5A, 0, 1'b0, 1'b1, 2 * BIT);

    check("8N1 words outstanding", 32'(q_a.size()), 32'h0);
    check("8E1 words outstanding", 32'(q_p.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
